// File: rtl/y_move_pkg.sv
// Shared types and parameter defaults for the player Y-movement controller.
package y_move_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_REPEAT} state_e;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 8;
   localparam int DEF_REPEAT_RATE     = 2;

   // Exactly one key held gives a direction; none or both means no movement.
   function automatic dir_e decode_dir(input logic up_n, input logic down_n);
      dir_e d;
      d = DIR_NONE;
      if (!up_n && down_n)
         d = DIR_UP;
      else if (up_n && !down_n)
         d = DIR_DOWN;
      return d;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key front end: 2-flop synchronizer followed by a consecutive-sample debouncer.
module key_debounce
   import y_move_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   output logic level_n
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         // Level flips on the sample after the counter has seen the full run of differing samples.
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign level_n = level_q;

endmodule

// File: rtl/y_move_ctrl.sv
// Player Y-movement controller: debounced keys -> frame-paced inc/dec step pulses.
// Auto-repeat is built only when Y_MOVE_AUTOREPEAT_EN is defined; otherwise one step per press.
module y_move_ctrl
   import y_move_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_up_n,
   input  logic key_down_n,
   input  logic frame_tick,
   output logic inc,
   output logic dec
);

   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("y_move_ctrl: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   logic   up_lvl_n;
   logic   down_lvl_n;
   dir_e   decode;
   state_e state_q;
   dir_e   dir_q;
   logic   inc_q;
   logic   dec_q;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n   (key_up_n),
      .level_n (up_lvl_n)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n   (key_down_n),
      .level_n (down_lvl_n)
   );

   assign decode = decode_dir(up_lvl_n, down_lvl_n);

`ifdef Y_MOVE_AUTOREPEAT_EN
   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX + 1);

   logic [TW-1:0] tcnt_q;
   logic [TW-1:0] tcnt_d;

   assign tcnt_d = tcnt_q + TW'(1);
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         dir_q   <= DIR_NONE;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
`ifdef Y_MOVE_AUTOREPEAT_EN
         tcnt_q  <= '0;
`endif
      end else begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
         if (state_q == S_IDLE) begin
            // A tick coinciding with arming is deliberately ignored.
            if (decode != DIR_NONE) begin
               state_q <= S_ARMED;
               dir_q   <= decode;
            end
         end else if (decode != dir_q) begin
            // Release, chord or swap wins over any coincident tick.
            state_q <= S_IDLE;
         end else if (frame_tick) begin
            case (state_q)
               S_ARMED: begin
                  inc_q   <= (dir_q == DIR_UP);
                  dec_q   <= (dir_q == DIR_DOWN);
                  state_q <= S_DELAY;
`ifdef Y_MOVE_AUTOREPEAT_EN
                  tcnt_q  <= '0;
`endif
               end
`ifdef Y_MOVE_AUTOREPEAT_EN
               S_DELAY: begin
                  if (tcnt_d == TW'(REPEAT_DELAY)) begin
                     inc_q   <= (dir_q == DIR_UP);
                     dec_q   <= (dir_q == DIR_DOWN);
                     tcnt_q  <= '0;
                     state_q <= S_REPEAT;
                  end else begin
                     tcnt_q <= tcnt_d;
                  end
               end
               S_REPEAT: begin
                  if (tcnt_d == TW'(REPEAT_RATE)) begin
                     inc_q  <= (dir_q == DIR_UP);
                     dec_q  <= (dir_q == DIR_DOWN);
                     tcnt_q <= '0;
                  end else begin
                     tcnt_q <= tcnt_d;
                  end
               end
`else
               S_DELAY: begin
                  state_q <= S_DELAY;
               end
`endif
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign inc = inc_q;
   assign dec = dec_q;

endmodule

// File: tb/tb_y_move_ctrl.sv
// Randomized and directed bench for y_move_ctrl against a trace-level reference model.
module tb_y_move_ctrl;

   localparam int DB = 4;
   localparam int RD = 3;
   localparam int RR = 2;
`ifdef Y_MOVE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n, key_up_n, key_down_n, frame_tick;
   logic inc, dec;

   int n_chk = 0, n_err = 0, cyc = 0;
   int obs_inc, obs_dec, exp_inc_n, exp_dec_n;

   // reference model state: raw-sample pipeline, synced-sample history, levels, press episode
   bit         m_p1 [2];
   bit         m_p2 [2];
   bit         m_lvl[2];
   logic [1:0] hq[$];
   bit         m_act;
   int         m_dir, m_k;
   bit         e_inc, e_dec;

   always #5 clock = ~clock;

   y_move_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .key_up_n   (key_up_n),
      .key_down_n (key_down_n),
      .frame_tick (frame_tick),
      .inc        (inc),
      .dec        (dec)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Steps fall on tick 1 after arming, then tick 1+RD, then every RR ticks.
   function automatic bit is_step(int k);
      return (k == 1) || (AR && k >= 1 + RD && ((k - 1 - RD) % RR) == 0);
   endfunction

   task automatic model_edge(bit rst_n, bit ru, bit rdn, bit tk);
      bit raw[2];
      bit s, all_diff;
      int dcd;
      logic [1:0] smp;
      raw[0] = ru;
      raw[1] = rdn;
      e_inc = 0;
      e_dec = 0;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_p1[i] = 1; m_p2[i] = 1; m_lvl[i] = 1;
         end
         hq.delete();
         m_act = 0;
         m_k   = 0;
         return;
      end
      dcd = (!m_lvl[0] && m_lvl[1]) ? 1 : (m_lvl[0] && !m_lvl[1]) ? 2 : 0;
      if (!m_act) begin
         if (dcd != 0) begin
            m_act = 1; m_dir = dcd; m_k = 0;
         end
      end else if (dcd != m_dir) begin
         m_act = 0;
      end else if (tk) begin
         m_k++;
         if (is_step(m_k)) begin
            if (m_dir == 1) e_inc = 1;
            else            e_dec = 1;
         end
      end
      // Level takes the synced value once the last DB+1 synced samples all oppose it.
      for (int i = 0; i < 2; i++) begin
         smp[i]  = m_p2[i];
         m_p2[i] = m_p1[i];
         m_p1[i] = raw[i];
      end
      hq.push_back(smp);
      if (hq.size() > DB + 1) void'(hq.pop_front());
      if (hq.size() == DB + 1) begin
         for (int i = 0; i < 2; i++) begin
            all_diff = 1;
            for (int j = 0; j < hq.size(); j++)
               if (hq[j][i] == m_lvl[i]) all_diff = 0;
            s = smp[i];
            if (all_diff) m_lvl[i] = s;
         end
      end
   endtask

   task automatic cyc1();
      bit rs, ru, rdn, tk;
      frame_tick = (cyc % 10 == 9);
      rs = reset_n; ru = key_up_n; rdn = key_down_n; tk = frame_tick;
      @(posedge clock);
      model_edge(rs, ru, rdn, tk);
      #1;
      chk("inc", inc, e_inc);
      chk("dec", dec, e_dec);
      chk("excl", inc & dec, 0);
      obs_inc += int'(inc);
      obs_dec += int'(dec);
      exp_inc_n += int'(e_inc);
      exp_dec_n += int'(e_dec);
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc1();
   endtask

   task automatic clr_cnt();
      obs_inc = 0; obs_dec = 0; exp_inc_n = 0; exp_dec_n = 0;
   endtask

   initial begin
      bit found;
      clr_cnt();
      frame_tick = 0;

      // reset with both keys held, then keep up held and drop down
      reset_n = 0; key_up_n = 0; key_down_n = 0;
      run(3);
      chk("reset_inc", inc, 0);
      chk("reset_dec", dec, 0);
      reset_n = 1; key_down_n = 1;
      clr_cnt();
      run(DB + 3);
      chk("reset_no_early_inc", obs_inc, 0);
      run(40);
      chk("reset_then_inc", obs_inc, exp_inc_n);
      key_up_n = 1;
      run(20);

      // glitch shorter than the debounce window
      clr_cnt();
      key_up_n = 0; run(3);
      key_up_n = 1; run(30);
      chk("glitch_inc", obs_inc, 0);

      // held up key
      clr_cnt();
      key_up_n = 0; run(120);
      key_up_n = 1; run(20);
      chk("held_inc", obs_inc, exp_inc_n);
      chk("held_inc_multi", obs_inc > 1, AR);
      chk("held_dec", obs_dec, 0);

      // both keys, then release down
      clr_cnt();
      key_up_n = 0; key_down_n = 0; run(60);
      chk("both_none", obs_inc + obs_dec, 0);
      key_down_n = 1; run(40);
      chk("both_then_up", obs_inc, exp_inc_n);
      chk("both_then_up_some", obs_inc >= 1, 1);
      key_up_n = 1; run(20);

      // release whose debounced edge lands on a step tick
      key_up_n = 0;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (m_act && m_dir == 1 && (cyc % 10 == 2) &&
             (AR ? (m_k >= RD + 1 && ((m_k - RD) % RR) == 0) : (m_k >= 1)))
            found = 1;
         else
            cyc1();
      end
      chk("rel_tick_found", found, 1);
      clr_cnt();
      key_up_n = 1; run(15);
      chk("rel_tick_nopulse", obs_inc, 0);

      // held down key: one step without auto-repeat
      clr_cnt();
      key_down_n = 0; run(120);
      key_down_n = 1; run(20);
      chk("held_dn_dec", obs_dec, AR ? exp_dec_n : 1);
      chk("held_dn_inc", obs_inc, 0);

      // random key patterns with occasional reset
      clr_cnt();
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 49) == 0) begin
            reset_n = 0; run(2); reset_n = 1;
         end
         key_up_n   = $urandom_range(0, 1);
         key_down_n = $urandom_range(0, 1);
         run($urandom_range(1, 40));
      end
      chk("rand_inc_total", obs_inc, exp_inc_n);
      chk("rand_dec_total", obs_dec, exp_dec_n);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
